// File: rtl/maf_pipe.sv
// Three-stage pipelined unsigned multiply-add: MUL, ADD, FMA and a running MAC accumulator.
// A single global advance signal gives valid/ready backpressure; there is no bubble collapsing.
module maf_pipe #(
    parameter int WIDTH = 32,
    parameter int RW    = 2*WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [1:0]       in_func,
    input  logic             in_acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_result,
    output logic             out_ovf,
    output logic [RW-1:0]    acc_value
);
    typedef enum logic [1:0] {
        F_MUL = 2'b00,
        F_ADD = 2'b01,
        F_FMA = 2'b10,
        F_MAC = 2'b11
    } func_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        func_t            func;
        logic             acc_clr;
    } s1_t;

    typedef struct packed {
        logic [RW-1:0]    p;
        logic [WIDTH-1:0] c;
        func_t            func;
        logic             acc_clr;
    } s2_t;

    logic [3:1]    vld_pipe;
    logic          advance;
    s1_t           s1;
    s2_t           s2;
    logic [RW-1:0] mult;
    logic [RW-1:0] prod;
    logic [RW-1:0] addend;
    logic [RW:0]   sum;
    logic [RW-1:0] acc;

    assign advance   = !vld_pipe[3] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[3];
    assign acc_value = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_pipe <= '0;
        else if (advance)
            vld_pipe <= {vld_pipe[2:1], in_valid};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s1 <= '0;
        else if (advance && in_valid)
            s1 <= '{a: in_a, b: in_b, c: in_c, func: func_t'(in_func), acc_clr: in_acc_clr};
    end

    // ADD reuses the multiplier with m = 1 so every mode shares the S3 adder.
    always_comb begin
        mult = (s1.func == F_ADD) ? RW'(1) : RW'(s1.b);
        prod = RW'(s1.a) * mult;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s2 <= '0;
        else if (advance && vld_pipe[1])
            s2 <= '{p: prod, c: s1.c, func: s1.func, acc_clr: s1.acc_clr};
    end

    always_comb begin
        addend = '0;
        case (s2.func)
            F_ADD, F_FMA: addend = {{(RW-WIDTH){1'b0}}, s2.c};
            F_MAC:        addend = s2.acc_clr ? '0 : acc;
            default:      addend = '0;
        endcase
        sum = {1'b0, s2.p} + {1'b0, addend};
    end

    // The accumulator is read and written on the same S3 load, so chained MACs see no hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result <= '0;
            out_ovf    <= 1'b0;
            acc        <= '0;
        end else if (advance && vld_pipe[2]) begin
            out_result <= sum[RW-1:0];
            out_ovf    <= sum[RW];
            if (s2.func == F_MAC)
                acc <= sum[RW-1:0];
        end
    end
endmodule

// File: tb/tb_maf_pipe.sv
// Directed bench for maf_pipe: single-op vector table, MAC streams with and without stalls, mid-flight reset.
module tb_maf_pipe;
    localparam int WIDTH = 32;
    localparam int RW    = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [WIDTH-1:0] in_c = '0;
    logic [1:0]       in_func = '0;
    logic             in_acc_clr = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [RW-1:0]    out_result;
    logic             out_ovf;
    logic [RW-1:0]    acc_value;

    maf_pipe #(.WIDTH(WIDTH), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .in_func(in_func), .in_acc_clr(in_acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf),
        .acc_value(acc_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       func;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic             clr;
        logic [RW-1:0]    res;
        logic             ovf;
        logic [RW-1:0]    acc;
    } vec_t;

    localparam logic [1:0] MUL = 2'b00, ADD = 2'b01, FMA = 2'b10, MAC = 2'b11;

    vec_t vecs[10];
    vec_t sops[8];
    int   nops;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [RW-1:0] got[$];
    int            got_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!rst && out_valid && out_ready) begin
            got.push_back(out_result);
            got_cyc.push_back(cyc);
        end

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_func = v.func; in_a = v.a; in_b = v.b; in_c = v.c; in_acc_clr = v.clr;
        in_valid = 1'b1;
    endtask

    // Issue one op and measure cycles from acceptance to out_valid; called at posedge+1.
    task automatic run_op(input vec_t v, input string name);
        int n;
        drive(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " latency"}, RW'(n), RW'(3));
        chk({name, " result"}, out_result, v.res);
        chk({name, " ovf"}, RW'(out_ovf), RW'(v.ovf));
        chk({name, " acc"}, acc_value, v.acc);
        @(posedge clk); #1;
    endtask

    // Stream sops[0..nops-1] honoring in_ready; optionally drop out_ready for 4 cycles.
    task automatic run_stream(input string name, input int stall_at, input bit consec);
        int g;
        got.delete();
        got_cyc.delete();
        fork
            begin
                bit ok;
                int w;
                for (int i = 0; i < nops; i++) begin
                    drive(sops[i]);
                    ok = 1'b0;
                    w = 0;
                    while (!ok && w < 50) begin
                        @(negedge clk);
                        ok = in_ready;
                        @(posedge clk); #1;
                        w++;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                logic [RW-1:0] hold;
                if (stall_at >= 0) begin
                    repeat (stall_at) @(posedge clk);
                    #1 out_ready = 1'b0;
                    hold = out_result;
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        chk({name, " stall in_ready"}, RW'(in_ready), RW'(0));
                        chk({name, " stall out_valid"}, RW'(out_valid), RW'(1));
                        chk({name, " stall hold"}, out_result, hold);
                        @(posedge clk); #1;
                    end
                    out_ready = 1'b1;
                end
            end
        join
        g = 0;
        while (got.size() < nops && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk({name, " count"}, RW'(got.size()), RW'(nops));
        for (int i = 0; i < nops && i < got.size(); i++) begin
            chk($sformatf("%s res[%0d]", name, i), got[i], sops[i].res);
            if (consec && i > 0)
                chk($sformatf("%s gap[%0d]", name, i), RW'(got_cyc[i] - got_cyc[i-1]), RW'(1));
        end
    endtask

    initial begin
        vecs[0] = '{MUL, 32'd7, 32'd6, 32'd0, 1'b0, 64'd42, 1'b0, 64'd0};
        vecs[1] = '{ADD, 32'd5, 32'd99, 32'd9, 1'b0, 64'd14, 1'b0, 64'd0};
        vecs[2] = '{FMA, 32'd3, 32'd4, 32'd10, 1'b0, 64'd22, 1'b0, 64'd0};
        vecs[3] = '{FMA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
                    64'hFFFFFFFF00000000, 1'b0, 64'd0};
        vecs[4] = '{MAC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 1'b1,
                    64'hFFFFFFFE00000001, 1'b0, 64'hFFFFFFFE00000001};
        vecs[5] = '{MAC, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0,
                    64'hFFFFFFFFFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF};
        vecs[6] = '{MAC, 32'd1, 32'd1, 32'd0, 1'b0, 64'd0, 1'b1, 64'd0};
        vecs[7] = '{MUL, 32'd2, 32'd3, 32'd0, 1'b0, 64'd6, 1'b0, 64'd0};
        vecs[8] = '{MAC, 32'd4, 32'd5, 32'd77, 1'b0, 64'd20, 1'b0, 64'd20};
        vecs[9] = '{MAC, 32'd3, 32'd3, 32'd0, 1'b1, 64'd9, 1'b0, 64'd9};

        #1;
        chk("reset out_valid", RW'(out_valid), RW'(0));
        chk("reset out_result", out_result, RW'(0));
        chk("reset out_ovf", RW'(out_ovf), RW'(0));
        chk("reset acc", acc_value, RW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset in_ready", RW'(in_ready), RW'(1));

        for (int i = 0; i < 10; i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        nops = 8;
        for (int i = 0; i < 8; i++) begin
            int s;
            s = (i + 1) * (i + 2);
            sops[i] = '{MAC, WIDTH'(i + 1), 32'd2, 32'd0, (i == 0), RW'(s), 1'b0, RW'(s)};
        end
        run_stream("mac stream", -1, 1'b1);
        chk("mac stream acc", acc_value, RW'(72));

        run_stream("mac stall", 4, 1'b0);
        chk("mac stall acc", acc_value, RW'(72));

        nops = 3;
        sops[0] = '{MAC, 32'd2, 32'd3, 32'd0, 1'b1, 64'd6, 1'b0, 64'd6};
        sops[1] = '{MUL, 32'd2, 32'd3, 32'd0, 1'b0, 64'd6, 1'b0, 64'd6};
        sops[2] = '{MAC, 32'd2, 32'd3, 32'd0, 1'b0, 64'd12, 1'b0, 64'd12};
        run_stream("interleave", -1, 1'b1);
        chk("interleave acc", acc_value, RW'(12));

        drive('{MAC, 32'd1, 32'd1, 32'd0, 1'b0, 64'd0, 1'b0, 64'd0});
        repeat (3) @(posedge clk);
        #1;
        chk("inflight out_valid", RW'(out_valid), RW'(1));
        rst = 1'b1;
        #1;
        chk("async rst out_valid", RW'(out_valid), RW'(0));
        chk("async rst acc", acc_value, RW'(0));
        chk("async rst out_result", out_result, RW'(0));
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_op('{MUL, 32'd2, 32'd3, 32'd0, 1'b0, 64'd6, 1'b0, 64'd0}, "post rst mul");
        repeat (3) @(posedge clk);
        #1;
        chk("drained out_valid", RW'(out_valid), RW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
